// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator car controller and the button block.
package elevator_pkg;

  localparam int BUTTONS_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    OPEN  = 2'd2,
    CLOSE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_t;

endpackage

// File: rtl/req_scan.sv
// Combinational request scanner: looks at the request vectors relative to one
// floor and reports pending work above/below, whether a moving car should stop
// there, and which latched requests a stop there services.
module req_scan import elevator_pkg::*; #(
  parameter int BUTTONS_WIDTH = BUTTONS_WIDTH_DEFAULT,
  parameter int FLOOR_W       = $clog2(BUTTONS_WIDTH)
) (
  input  logic [BUTTONS_WIDTH-1:0] in_levels,
  input  logic [BUTTONS_WIDTH-2:0] up_levels,
  input  logic [BUTTONS_WIDTH-1:1] down_levels,
  input  logic [FLOOR_W-1:0]       floor,
  input  logic [1:0]               dir,
  output logic                     here,
  output logic                     above,
  output logic                     below,
  output logic                     stop,
  output logic [BUTTONS_WIDTH-1:0] clear_in,
  output logic [BUTTONS_WIDTH-2:0] clear_up,
  output logic [BUTTONS_WIDTH-1:1] clear_down
);

  logic [BUTTONS_WIDTH-1:0] up_full;
  logic [BUTTONS_WIDTH-1:0] down_full;
  logic [BUTTONS_WIDTH-1:0] req;
  logic                     going_up;
  logic                     going_down;

  assign going_up   = (dir == DIR_UP);
  assign going_down = (dir == DIR_DOWN);

  // Merge the three request sources per floor and look for work on either side.
  always_comb begin
    up_full                       = '0;
    up_full[BUTTONS_WIDTH-2:0]    = up_levels;
    down_full                     = '0;
    down_full[BUTTONS_WIDTH-1:1]  = down_levels;
    req                           = in_levels | up_full | down_full;
    above                         = 1'b0;
    below                         = 1'b0;
    for (int f = 0; f < BUTTONS_WIDTH; f++) begin
      if (f > int'(floor)) above = above | req[f];
      if (f < int'(floor)) below = below | req[f];
    end
  end

  // Stop decision and service masks; the opposite hall call is also serviced
  // when nothing lies further in the travel direction, since the car reverses.
  always_comb begin
    here = req[floor];
    if (going_up)        stop = in_levels[floor] | up_full[floor] | ~above;
    else if (going_down) stop = in_levels[floor] | down_full[floor] | ~below;
    else                 stop = here;
    clear_in   = '0;
    clear_up   = '0;
    clear_down = '0;
    for (int f = 0; f < BUTTONS_WIDTH; f++)
      if (int'(floor) == f) clear_in[f] = in_levels[f];
    for (int f = 0; f < BUTTONS_WIDTH - 1; f++)
      if (int'(floor) == f) clear_up[f] = up_levels[f] & (~going_down | ~below);
    for (int f = 1; f < BUTTONS_WIDTH; f++)
      if (int'(floor) == f) clear_down[f] = down_levels[f] & (~going_up | ~above);
  end

endmodule

// File: rtl/elevator_ctrl.sv
// Elevator car controller: collective (SCAN) scheduling of latched requests,
// motor and door sequencing, and one-cycle clear pulses back to the buttons.
module elevator_ctrl import elevator_pkg::*; #(
  parameter int BUTTONS_WIDTH = BUTTONS_WIDTH_DEFAULT,
  parameter int FLOOR_TIME    = 16,
  parameter int DOOR_TIME     = 32,
  parameter int FLOOR_W       = $clog2(BUTTONS_WIDTH)
) (
  input  logic                     clk,
  input  logic                     an_reset,
  input  logic [BUTTONS_WIDTH-1:0] active_in_levels,
  input  logic [BUTTONS_WIDTH-2:0] active_out_up_levels,
  input  logic [BUTTONS_WIDTH-1:1] active_out_down_levels,
  input  logic                     emergency_stop,
  output logic [BUTTONS_WIDTH-1:0] inactivate_in_levels,
  output logic [BUTTONS_WIDTH-2:0] inactivate_out_up_levels,
  output logic [BUTTONS_WIDTH-1:1] inactivate_out_down_levels,
  output logic                     buttons_block,
  output logic [FLOOR_W-1:0]       current_floor,
  output logic [1:0]               direction,
  output logic                     motor_up,
  output logic                     motor_down,
  output logic                     door_open
);

  localparam int TIMER_MAX = (FLOOR_TIME > DOOR_TIME) ? FLOOR_TIME : DOOR_TIME;
  localparam int TIMER_W   = $clog2(TIMER_MAX);
  localparam int MASK_W    = 3 * BUTTONS_WIDTH - 2;
  localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(BUTTONS_WIDTH - 1);
  localparam logic [TIMER_W-1:0] FLOOR_LAST = TIMER_W'(FLOOR_TIME - 1);
  localparam logic [TIMER_W-1:0] DOOR_LAST  = TIMER_W'(DOOR_TIME - 1);

  state_t                   state;
  dir_t                     dir;
  logic [FLOOR_W-1:0]       floor_r;
  logic [FLOOR_W-1:0]       scan_floor;
  logic [TIMER_W-1:0]       timer;
  logic                     motor_up_r;
  logic                     motor_down_r;
  logic                     door_r;
  logic                     block_r;
  logic [BUTTONS_WIDTH-1:0] pulse_in;
  logic [BUTTONS_WIDTH-2:0] pulse_up;
  logic [BUTTONS_WIDTH-1:1] pulse_down;
  logic [MASK_W-1:0]        mask;
  logic [MASK_W-1:0]        prev_mask;

  logic                     here;
  logic                     above;
  logic                     below;
  logic                     stop;
  logic [BUTTONS_WIDTH-1:0] clear_in;
  logic [BUTTONS_WIDTH-2:0] clear_up;
  logic [BUTTONS_WIDTH-1:1] clear_down;
  logic                     go_up;
  logic                     go_down;

  // While moving, evaluate the floor being arrived at so the stop decision and
  // the clear pulses line up with the edge that updates current_floor.
  always_comb begin
    scan_floor = floor_r;
    if (state == MOVE) begin
      if (dir == DIR_UP && floor_r != TOP_FLOOR)   scan_floor = floor_r + FLOOR_W'(1);
      else if (dir == DIR_DOWN && floor_r != '0)   scan_floor = floor_r - FLOOR_W'(1);
    end
  end

  req_scan #(
    .BUTTONS_WIDTH(BUTTONS_WIDTH),
    .FLOOR_W      (FLOOR_W)
  ) u_scan (
    .in_levels  (active_in_levels),
    .up_levels  (active_out_up_levels),
    .down_levels(active_out_down_levels),
    .floor      (scan_floor),
    .dir        (dir),
    .here       (here),
    .above      (above),
    .below      (below),
    .stop       (stop),
    .clear_in   (clear_in),
    .clear_up   (clear_up),
    .clear_down (clear_down)
  );

  assign mask    = {clear_in, clear_up, clear_down};
  assign go_up   = above & ((dir != DIR_DOWN) | ~below);
  assign go_down = below & ~go_up;

  // Car sequencer: timers, floor position, direction and all registered outputs.
  always_ff @(posedge clk or posedge an_reset) begin
    if (an_reset) begin
      state        <= IDLE;
      dir          <= DIR_NONE;
      floor_r      <= '0;
      timer        <= '0;
      motor_up_r   <= 1'b0;
      motor_down_r <= 1'b0;
      door_r       <= 1'b0;
      block_r      <= 1'b0;
      pulse_in     <= '0;
      pulse_up     <= '0;
      pulse_down   <= '0;
      prev_mask    <= '0;
    end else begin
      block_r    <= emergency_stop;
      pulse_in   <= '0;
      pulse_up   <= '0;
      pulse_down <= '0;
      if (!emergency_stop) begin
        case (state)
          IDLE: begin
            if (here) begin
              state      <= OPEN;
              door_r     <= 1'b1;
              timer      <= '0;
              pulse_in   <= clear_in;
              pulse_up   <= clear_up;
              pulse_down <= clear_down;
              prev_mask  <= mask;
            end else if (go_up) begin
              state      <= MOVE;
              dir        <= DIR_UP;
              motor_up_r <= 1'b1;
              timer      <= '0;
            end else if (go_down) begin
              state        <= MOVE;
              dir          <= DIR_DOWN;
              motor_down_r <= 1'b1;
              timer        <= '0;
            end
          end
          MOVE: begin
            if (timer == FLOOR_LAST) begin
              timer   <= '0;
              floor_r <= scan_floor;
              if (stop) begin
                state        <= OPEN;
                motor_up_r   <= 1'b0;
                motor_down_r <= 1'b0;
                door_r       <= 1'b1;
                pulse_in     <= clear_in;
                pulse_up     <= clear_up;
                pulse_down   <= clear_down;
                prev_mask    <= mask;
              end
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end
          OPEN: begin
            prev_mask <= mask;
            if (|(mask & ~prev_mask)) begin
              timer      <= '0;
              pulse_in   <= clear_in;
              pulse_up   <= clear_up;
              pulse_down <= clear_down;
            end else if (timer == DOOR_LAST) begin
              state  <= CLOSE;
              door_r <= 1'b0;
              timer  <= '0;
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end
          CLOSE: begin
            timer <= '0;
            if (go_up) begin
              state      <= MOVE;
              dir        <= DIR_UP;
              motor_up_r <= 1'b1;
            end else if (go_down) begin
              state        <= MOVE;
              dir          <= DIR_DOWN;
              motor_down_r <= 1'b1;
            end else begin
              state <= IDLE;
              dir   <= DIR_NONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign inactivate_in_levels       = pulse_in;
  assign inactivate_out_up_levels   = pulse_up;
  assign inactivate_out_down_levels = pulse_down;
  assign buttons_block              = block_r;
  assign current_floor              = floor_r;
  assign direction                  = dir;
  assign motor_up                   = motor_up_r & ~emergency_stop;
  assign motor_down                 = motor_down_r & ~emergency_stop;
  assign door_open                  = door_r;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Self-checking bench for elevator_ctrl with a simple button-block model:
// requests latch when pressed and drop when the controller pulses their clear.
module tb_elevator_ctrl;

  localparam int W    = 8;
  localparam int FT   = 4;
  localparam int DT   = 3;
  localparam int K_IN = 0;
  localparam int K_UP = 16;
  localparam int K_DN = 32;

  logic           clk = 1'b0;
  logic           an_reset;
  logic [W-1:0]   in_lv;
  logic [W-2:0]   up_lv;
  logic [W-1:1]   dn_lv;
  logic           estop;
  logic [W-1:0]   inactivate_in_levels;
  logic [W-2:0]   inactivate_out_up_levels;
  logic [W-1:1]   inactivate_out_down_levels;
  logic           buttons_block;
  logic [2:0]     current_floor;
  logic [1:0]     direction;
  logic           motor_up;
  logic           motor_down;
  logic           door_open;

  int compared   = 0;
  int mismatched = 0;
  int exp_q[$];

  int cyc, mu_cyc, md_cyc, door_cyc, pulse_cnt, max_floor;
  int first_step_tick, last_pulse_tick, pulse_gap;
  bit both_seen;
  logic [2:0] start_floor;
  logic [30:0] obs;

  elevator_ctrl #(
    .BUTTONS_WIDTH(W),
    .FLOOR_TIME   (FT),
    .DOOR_TIME    (DT)
  ) dut (
    .clk                       (clk),
    .an_reset                  (an_reset),
    .active_in_levels          (in_lv),
    .active_out_up_levels      (up_lv),
    .active_out_down_levels    (dn_lv),
    .emergency_stop            (estop),
    .inactivate_in_levels      (inactivate_in_levels),
    .inactivate_out_up_levels  (inactivate_out_up_levels),
    .inactivate_out_down_levels(inactivate_out_down_levels),
    .buttons_block             (buttons_block),
    .current_floor             (current_floor),
    .direction                 (direction),
    .motor_up                  (motor_up),
    .motor_down                (motor_down),
    .door_open                 (door_open)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic reset_stats();
    cyc = 0; mu_cyc = 0; md_cyc = 0; door_cyc = 0; pulse_cnt = 0;
    max_floor = int'(current_floor); first_step_tick = 0;
    last_pulse_tick = 0; pulse_gap = 0; both_seen = 0;
    start_floor = current_floor;
  endtask

  task automatic do_reset();
    an_reset = 1'b1;
    in_lv = '0; up_lv = '0; dn_lv = '0; estop = 1'b0;
    repeat (2) @(negedge clk);
    an_reset = 1'b0;
  endtask

  // One cycle: sample on the falling edge, score clear pulses, update the
  // button model (clears drop the latched request).
  task automatic tick();
    logic [W-1:0] p_in, p_up, p_dn;
    bit b;
    int e;
    @(negedge clk);
    cyc++;
    if (motor_up) mu_cyc++;
    if (motor_down) md_cyc++;
    if (door_open) door_cyc++;
    if (motor_up && motor_down) both_seen = 1;
    if (int'(current_floor) > max_floor) max_floor = int'(current_floor);
    if (first_step_tick == 0 && current_floor != start_floor) first_step_tick = cyc;
    p_in = inactivate_in_levels;
    p_up = '0; p_up[W-2:0] = inactivate_out_up_levels;
    p_dn = '0; p_dn[W-1:1] = inactivate_out_down_levels;
    if (|{p_in, p_up, p_dn}) begin
      if (last_pulse_tick > 0) pulse_gap = cyc - last_pulse_tick;
      last_pulse_tick = cyc;
    end
    for (int k = 0; k < 3; k++) begin
      for (int f = 0; f < W; f++) begin
        b = (k == 0) ? p_in[f] : (k == 1) ? p_up[f] : p_dn[f];
        if (b) begin
          pulse_cnt++;
          compared++;
          if (exp_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL pulse_unexpected: got kind %0d floor %0d, expected none", k, f);
          end else begin
            e = exp_q.pop_front();
            if ((k * 16 + f) !== e || door_open !== 1'b1) begin
              mismatched++;
              $display("[TB] FAIL pulse: got kind %0d floor %0d door %0b, expected kind %0d floor %0d door 1",
                       k, f, door_open, e / 16, e % 16);
            end
          end
        end
      end
    end
    in_lv = in_lv & ~inactivate_in_levels;
    up_lv = up_lv & ~inactivate_out_up_levels;
    dn_lv = dn_lv & ~inactivate_out_down_levels;
  endtask

  task automatic test_reset();
    @(negedge clk);
    obs = {inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels,
           buttons_block, current_floor, direction, motor_up, motor_down, door_open};
    compared++;
    if (obs !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %h, expected 0", obs);
    end
    an_reset = 1'b0;
    reset_stats();
    repeat (3) tick();
    compared++;
    if ({direction, motor_up, motor_down, door_open, current_floor} !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL reset_idle: got dir %0d mu %0b md %0b door %0b floor %0d, expected all 0",
               direction, motor_up, motor_down, door_open, current_floor);
    end
  endtask

  task automatic test_single_cab();
    reset_stats();
    in_lv[3] = 1'b1;
    exp_q.push_back(K_IN + 3);
    repeat (24) tick();
    compared++;
    if (mu_cyc !== 3 * FT || md_cyc !== 0) begin
      mismatched++;
      $display("[TB] FAIL cab_motor: got up %0d down %0d cycles, expected %0d and 0", mu_cyc, md_cyc, 3 * FT);
    end
    compared++;
    if (first_step_tick !== FT + 1) begin
      mismatched++;
      $display("[TB] FAIL cab_first_step: got tick %0d, expected %0d", first_step_tick, FT + 1);
    end
    compared++;
    if (door_cyc !== DT || pulse_cnt !== 1) begin
      mismatched++;
      $display("[TB] FAIL cab_door: got door %0d pulses %0d, expected %0d and 1", door_cyc, pulse_cnt, DT);
    end
    compared++;
    if (current_floor !== 3'd3 || direction !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL cab_final: got floor %0d dir %0d, expected 3 and 0", current_floor, direction);
    end
  endtask

  task automatic test_collective();
    do_reset();
    reset_stats();
    up_lv[2] = 1'b1; dn_lv[5] = 1'b1; in_lv[6] = 1'b1;
    exp_q.push_back(K_UP + 2);
    exp_q.push_back(K_IN + 6);
    exp_q.push_back(K_DN + 5);
    repeat (55) tick();
    compared++;
    if (exp_q.size() !== 0) begin
      mismatched++;
      $display("[TB] FAIL coll_pending: got %0d outstanding pulses, expected 0", exp_q.size());
    end
    compared++;
    if (door_cyc !== 3 * DT || mu_cyc !== 6 * FT || md_cyc !== FT) begin
      mismatched++;
      $display("[TB] FAIL coll_timing: got door %0d up %0d down %0d, expected %0d %0d %0d",
               door_cyc, mu_cyc, md_cyc, 3 * DT, 6 * FT, FT);
    end
    compared++;
    if (current_floor !== 3'd5 || max_floor !== 6 || direction !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL coll_final: got floor %0d max %0d dir %0d, expected 5 6 0",
               current_floor, max_floor, direction);
    end
  endtask

  task automatic test_door_reopen();
    reset_stats();
    in_lv[4] = 1'b1;
    exp_q.push_back(K_IN + 4);
    exp_q.push_back(K_IN + 4);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (door_open) break;
    end
    compared++;
    if (door_open !== 1'b1 || current_floor !== 3'd4) begin
      mismatched++;
      $display("[TB] FAIL reopen_arrive: got door %0b floor %0d, expected 1 and 4", door_open, current_floor);
    end
    tick();
    in_lv[4] = 1'b1;
    repeat (8) tick();
    compared++;
    if (pulse_cnt !== 2 || pulse_gap !== 2) begin
      mismatched++;
      $display("[TB] FAIL reopen_pulses: got count %0d gap %0d, expected 2 and 2", pulse_cnt, pulse_gap);
    end
    compared++;
    if (door_cyc !== 2 + DT) begin
      mismatched++;
      $display("[TB] FAIL reopen_door: got %0d open cycles, expected %0d", door_cyc, 2 + DT);
    end
  endtask

  task automatic test_emergency();
    reset_stats();
    in_lv[5] = 1'b1;
    exp_q.push_back(K_IN + 5);
    repeat (2) tick();
    estop = 1'b1;
    #1;
    compared++;
    if (motor_up !== 1'b0 || motor_down !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL estop_motor: got up %0b down %0b, expected 0 0", motor_up, motor_down);
    end
    tick();
    compared++;
    if (buttons_block !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL estop_block: got %0b, expected 1", buttons_block);
    end
    repeat (4) tick();
    estop = 1'b0;
    tick();
    compared++;
    if (buttons_block !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL estop_unblock: got %0b, expected 0", buttons_block);
    end
    repeat (10) tick();
    compared++;
    if (first_step_tick !== FT + 5 + 1 || mu_cyc !== FT) begin
      mismatched++;
      $display("[TB] FAIL estop_resume: got step tick %0d motor %0d, expected %0d and %0d",
               first_step_tick, mu_cyc, FT + 6, FT);
    end
    compared++;
    if (current_floor !== 3'd5 || door_cyc !== DT) begin
      mismatched++;
      $display("[TB] FAIL estop_final: got floor %0d door %0d, expected 5 and %0d", current_floor, door_cyc, DT);
    end
  endtask

  task automatic test_top_boundary();
    reset_stats();
    in_lv[7] = 1'b1;
    exp_q.push_back(K_IN + 7);
    repeat (16) tick();
    dn_lv[7] = 1'b1;
    in_lv[0] = 1'b1;
    exp_q.push_back(K_DN + 7);
    exp_q.push_back(K_IN + 0);
    reset_stats();
    tick();
    compared++;
    if (door_open !== 1'b1 || current_floor !== 3'd7) begin
      mismatched++;
      $display("[TB] FAIL top_open: got door %0b floor %0d, expected 1 and 7", door_open, current_floor);
    end
    repeat (45) tick();
    compared++;
    if (md_cyc !== 7 * FT || max_floor !== 7 || both_seen !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL top_travel: got down %0d max %0d both %0b, expected %0d 7 0",
               md_cyc, max_floor, both_seen, 7 * FT);
    end
    compared++;
    if (current_floor !== 3'd0 || direction !== 2'b00 || exp_q.size() !== 0) begin
      mismatched++;
      $display("[TB] FAIL top_final: got floor %0d dir %0d pending %0d, expected 0 0 0",
               current_floor, direction, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_move();
    reset_stats();
    in_lv[3] = 1'b1;
    repeat (FT + 2) tick();
    an_reset = 1'b1;
    #1;
    obs = {inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels,
           buttons_block, current_floor, direction, motor_up, motor_down, door_open};
    compared++;
    if (obs !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_move: got %h, expected 0", obs);
    end
    in_lv = '0;
    @(negedge clk);
    an_reset = 1'b0;
    repeat (4) tick();
    compared++;
    if ({direction, motor_up, motor_down, door_open, current_floor} !== 8'h00 || exp_q.size() !== 0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_idle: got dir %0d mu %0b door %0b floor %0d pending %0d, expected all 0",
               direction, motor_up, door_open, current_floor, exp_q.size());
    end
  endtask

  // Test sequence
  initial begin
    an_reset = 1'b1;
    in_lv = '0; up_lv = '0; dn_lv = '0; estop = 1'b0;
    test_reset();
    test_single_cab();
    test_collective();
    test_door_reopen();
    test_emergency();
    test_top_boundary();
    test_reset_mid_move();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/elevator_ctrl.md
# elevator_ctrl

Car controller for the elevator: consumes the latched hall/cab request vectors from the button block, schedules car travel with a collective (SCAN) policy, drives the motor and door, and returns one-cycle clear pulses for each request it services. It is the consumer end of the button block's active/inactivate interface and sits between that block and the motor/door actuators.

## Interface
- BUTTONS_WIDTH, 8: number of floors; floor 0 is the bottom.
- FLOOR_TIME, 16: clock cycles to travel one floor; at least 2.
- DOOR_TIME, 32: clock cycles the door stays open per stop; at least 2.
- FLOOR_W, $clog2(BUTTONS_WIDTH): floor index width (derived).
- clk  in  1  system clock, rising edge.
- an_reset  in  1  reset; asynchronous; active-high (1 = reset).
- active_in_levels  in  [BUTTONS_WIDTH-1:0]  cab requests, level.
- active_out_up_levels  in  [BUTTONS_WIDTH-2:0]  hall up requests, level.
- active_out_down_levels  in  [BUTTONS_WIDTH-1:1]  hall down requests, level.
- emergency_stop  in  1  level; freezes the car.
- inactivate_in_levels  out  [BUTTONS_WIDTH-1:0]  one-cycle clear pulses, cab.
- inactivate_out_up_levels  out  [BUTTONS_WIDTH-2:0]  one-cycle clear pulses, hall up.
- inactivate_out_down_levels  out  [BUTTONS_WIDTH-1:1]  one-cycle clear pulses, hall down.
- buttons_block  out  1  equals emergency_stop, registered.
- current_floor  out  FLOOR_W  car position.
- direction  out  2  00 none, 01 up, 10 down.
- motor_up, motor_down  out  1  motor drive; never both high.
- door_open  out  1  door command.

## Operation
- Reset drives every output to 0, current_floor to 0, state IDLE, timers to 0.
- Request at floor f: req[f] = in[f] | up[f] | down[f], with out-of-range bits treated as 0. above = any req above current_floor. below = any req below current_floor.
- **IDLE**, direction 00:
  - req[cur] → OPEN.
  - Else if above → direction 01, MOVE.
  - Else if below → direction 10, MOVE.
  - Up wins when both above and below are set.
- **MOVE**: motor_up or motor_down follows direction. The timer counts 0 to FLOOR_TIME-1. At terminal count, current_floor steps by ±1 and the timer clears.
  - Going up, the car stops at the new floor n if in[n] | up[n], or if there is no request above n.
  - Going down, the rule mirrors this, using down[n].
  - On a stop the state goes to OPEN and the motor drops. Otherwise the car stays in MOVE.
- **OPEN**: door_open is high for DOOR_TIME cycles. In the first OPEN cycle the block pulses clears:
  - always in[cur];
  - up[cur] if direction is up or none;
  - down[cur] if direction is down or none;
  - the opposite-direction hall bit as well if no request remains beyond cur in the travel direction (the car reverses).
- A new req[cur] that would be cleared, arriving during OPEN, restarts the door timer and re-pulses. Re-pulses are separated by at least one low cycle.
- **CLOSE**: a single cycle with door_open at 0. Decision:
  - Continue in the current direction if requests remain that way.
  - Else reverse if requests remain the other way.
  - Else go to IDLE with direction 00.
- **emergency_stop**:
  - Motors drop to 0 in the same cycle (combinational gate).
  - Timers and state hold.
  - door_open holds its value.
  - No clear pulses are issued.
  - buttons_block goes high the next cycle.
  - On release, the block resumes exactly where it stopped.

## Timing
- Floor-to-floor time is exactly FLOOR_TIME cycles. current_floor updates on the terminal-count edge.
- The stop decision uses request levels sampled in the terminal-count cycle.
- Clear pulses are registered: high exactly one cycle, which is the first cycle door_open is 1.
- A request seen in IDLE takes 1 cycle to reach MOVE or OPEN (registered outputs).
- A request cleared by a pulse and re-pressed in the same cycle stays active (the button block gives priority to the press). The controller services it again on the next visit.
- Asserting an_reset mid-MOVE or mid-OPEN forces all outputs to 0 immediately. No pulse is issued.
- current_floor never exceeds BUTTONS_WIDTH-1 or drops below 0. Direction is forced to none or reversed at the end floors.

## Structure
- Shared package elevator_pkg holds:
  - state encoding (IDLE, MOVE, OPEN, CLOSE);
  - direction encoding (DIR_NONE, DIR_UP, DIR_DOWN);
  - the BUTTONS_WIDTH default, also used by the button block.
- Sub-module req_scan (combinational): computes above, below and the stop/clear masks from the request vectors, current_floor and direction. The FSM and timers stay in elevator_ctrl.

## Test plan
Bench parameters: BUTTONS_WIDTH=8, FLOOR_TIME=4, DOOR_TIME=3.
- **Reset mid-move**: reset asserted at cycle 2 of MOVE → all outputs 0 and current_floor 0 in the same cycle. After release, IDLE.
- **Single cab call, upward**: at floor 0, active_in[3]=1 → motor_up for 12 cycles; current_floor goes 1, 2, 3; inactivate_in[3] pulses once with door_open=1 for 3 cycles; then IDLE, direction 00.
- **Collective stop and reversal**:
  - Requests: up[2], down[5], in[6], car at floor 0.
  - Car stops at 2, clearing up[2].
  - Car passes 5, stops at 6, clearing in[6].
  - Car reverses and stops at 5, clearing down[5].
- **Door re-open**: at floor 4 in OPEN, in[4] re-asserted in OPEN cycle 2 → second clear pulse after a low gap; the door timer restarts, door open 3 more cycles.
- **Emergency stop**: emergency_stop high for 5 cycles mid-floor → motors 0 immediately; buttons_block 1 one cycle later; the remaining floor time resumes after release, with total floor-to-floor time equal to 4 plus 5 cycles.
- **Top-floor boundary**: car at 7 with down[7] and in[0] → door opens at 7 and down[7] is cleared; the car moves down to 0; current_floor never exceeds 7.
